// File: rtl/lcd_cmd_sequencer.sv
// Command source for the LCD instruction FSM: issues the one-time configuration
// sequence, then refreshes both 16-character lines from a 32-byte buffer forever.
module lcd_cmd_sequencer #(
    parameter int unsigned CLEAR_WAIT = 82000,
    parameter int unsigned CNT_MAX    = 2080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        done,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        next_instruction,
    output logic [9:0]  db,
    output logic [11:0] clk_cnt,
    output logic        config_done,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_CLEAR_WAIT
    } state_t;

    localparam logic [11:0] CNT_TOP    = 12'(CNT_MAX);
    localparam logic [16:0] WAIT_LAST  = 17'(CLEAR_WAIT - 1);
    localparam logic [5:0]  STEP_CLEAR = 6'd3;
    localparam logic [5:0]  STEP_LINE1 = 6'd4;
    localparam logic [5:0]  STEP_LINE2 = 6'd21;
    localparam logic [5:0]  STEP_LAST  = 6'd37;

    state_t      state_q, state_d;
    logic [5:0]  step_q, step_d;
    logic [16:0] wait_cnt_q, wait_cnt_d;
    logic [11:0] clk_cnt_q, clk_cnt_d;
    logic [9:0]  db_q, db_d;
    logic        next_instruction_q, next_instruction_d;
    logic        config_done_q, config_done_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  buf_q [32];
    logic [7:0]  buf_d [32];

    logic [4:0]  char_idx;
    logic [9:0]  word;

    // Character buffer; writes are accepted regardless of sequencer state.
    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            buf_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else begin
            buf_q <= buf_d;
        end
    end

    // Steps 5-20 map to entries 0-15, steps 22-37 to entries 16-31.
    always_comb begin
        char_idx = '0;
        word     = '0;
        if (step_q > STEP_LINE2) begin
            char_idx = 5'(step_q - 6'd6);
        end else begin
            char_idx = 5'(step_q - 6'd5);
        end
        case (step_q)
            6'd0:       word = 10'h028;
            6'd1:       word = 10'h006;
            6'd2:       word = 10'h00C;
            6'd3:       word = 10'h001;
            STEP_LINE1: word = 10'h080;
            STEP_LINE2: word = 10'h0C0;
            default:    word = {2'b10, buf_q[char_idx]};
        endcase
    end

    always_comb begin
        state_d            = state_q;
        step_d             = step_q;
        wait_cnt_d         = wait_cnt_q;
        clk_cnt_d          = clk_cnt_q;
        db_d               = db_q;
        next_instruction_d = 1'b0;
        config_done_d      = config_done_q;
        frame_done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (init_done) begin
                    step_d  = '0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                next_instruction_d = 1'b1;
                db_d               = word;
                clk_cnt_d          = '0;
                // First line-1 address issue marks the end of configuration.
                if (step_q == STEP_LINE1) begin
                    config_done_d = 1'b1;
                end
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (clk_cnt_q < CNT_TOP) begin
                    clk_cnt_d = clk_cnt_q + 12'd1;
                end
                if (done) begin
                    if (step_q == STEP_CLEAR) begin
                        wait_cnt_d = '0;
                        clk_cnt_d  = '0;
                        state_d    = ST_CLEAR_WAIT;
                    end else begin
                        if (step_q == STEP_LAST) begin
                            step_d       = STEP_LINE1;
                            frame_done_d = 1'b1;
                        end else begin
                            step_d = step_q + 6'd1;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_CLEAR_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    step_d  = STEP_LINE1;
                    state_d = ST_ISSUE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 17'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            step_q             <= '0;
            wait_cnt_q         <= '0;
            clk_cnt_q          <= '0;
            db_q               <= '0;
            next_instruction_q <= 1'b0;
            config_done_q      <= 1'b0;
            frame_done_q       <= 1'b0;
        end else begin
            state_q            <= state_d;
            step_q             <= step_d;
            wait_cnt_q         <= wait_cnt_d;
            clk_cnt_q          <= clk_cnt_d;
            db_q               <= db_d;
            next_instruction_q <= next_instruction_d;
            config_done_q      <= config_done_d;
            frame_done_q       <= frame_done_d;
        end
    end

    assign next_instruction = next_instruction_q;
    assign db               = db_q;
    assign clk_cnt          = clk_cnt_q;
    assign config_done      = config_done_q;
    assign frame_done       = frame_done_q;

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Upstream command source for the LCD instruction FSM. After power-on initialisation completes, it issues the display configuration sequence. It then refreshes both 16-character lines continuously from a 32-byte character buffer. For each instruction it presents a 10-bit command word, pulses `next_instruction`, and generates the `clk_cnt` timebase that the instruction FSM steps through. It advances when the FSM returns `done`.

## Interface
Parameters:
- `CLEAR_WAIT`, 82000: extra idle cycles after the Clear Display instruction completes (1.64 ms at 50 MHz).
- `CNT_MAX`, 2080: terminal value of `clk_cnt`. Must match the instruction FSM's final state.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high.
- `init_done` in 1: level. Power-on initialisation is complete.
- `done` in 1: one-cycle pulse from the instruction FSM. The current instruction is complete.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in 5: buffer index. 0–15 is line 1, 16–31 is line 2.
- `wr_data` in 8: character code.
- `next_instruction` out 1: one-cycle pulse that starts an instruction.
- `db` out 10: command word. `[9]` is RS, `[8]` is RW, `[7:0]` is the data byte.
- `clk_cnt` out 12: instruction timebase.
- `config_done` out 1: level. The configuration sequence has finished.
- `frame_done` out 1: one-cycle pulse after the last character of line 2.

## Operation
- Buffer: 32×8 register array. Reset sets every entry to 0x20 (space).
- `wr_en` writes `wr_data` to `wr_addr` on the clock edge. Writes are accepted in every state.
- The instruction step index runs 0–37:
  - 0: 0x028 (Function Set)
  - 1: 0x006 (Entry Mode)
  - 2: 0x00C (Display On)
  - 3: 0x001 (Clear)
  - 4: 0x080 (Set DDRAM address, line 1)
  - 5–20: `{2'b10, buf[step-5]}`
  - 21: 0x0C0 (Set DDRAM address, line 2)
  - 22–37: `{2'b10, buf[step-6]}`
- After step 37 the index wraps to 4, not 0. Configuration is never reissued without a reset.
- FSM states:
  - IDLE: wait for `init_done`=1, then go to ISSUE with step=0.
  - ISSUE: for exactly one cycle, register `next_instruction`=1, `db`=word(step) and `clk_cnt`=0. Then go to WAIT_DONE.
  - WAIT_DONE: `clk_cnt` increments by 1 per cycle and saturates at `CNT_MAX`. When `done`=1:
    - step=3: go to CLEAR_WAIT.
    - otherwise: advance the step and go to ISSUE.
  - CLEAR_WAIT: count `CLEAR_WAIT` cycles with a 17-bit counter. Then set step=4, set `config_done`=1 and go to ISSUE.
- `db` is registered at ISSUE and held constant until the next ISSUE. A buffer write to the entry currently being sent does not alter `db` mid-instruction.
- `clk_cnt` is held at 0 in IDLE and CLEAR_WAIT. Outside WAIT_DONE it changes only at ISSUE.
- `frame_done` pulses for one cycle, in the cycle after `done` is sampled for step 37.
- `done` arriving outside WAIT_DONE is ignored.
- `init_done` is sampled only in IDLE.

## Timing
- Reset values:
  - `next_instruction`=0, `db`=0x000, `clk_cnt`=0, `config_done`=0, `frame_done`=0.
  - State IDLE, step=0, buffer all 0x20.
- Reset is asynchronous and aborts any instruction mid-flight. After release, the block restarts from IDLE and reissues the full configuration sequence.
- Start: `init_done` is sampled high at edge E. At edge E+1 the first `next_instruction` pulse begins, with `db`=0x028.
- Handshake:
  - `done` sampled high at edge D gives the next `next_instruction` at edge D+1.
  - `clk_cnt` reaches `CNT_MAX` at edge I+2080, where I is the issue edge.
  - Each instruction costs the FSM's 2080 cycles plus the `done` latency plus 1 issue cycle.
- Clear: `done` for step 3 at edge D, then the 0x080 issue at edge D+1+`CLEAR_WAIT`.
- `config_done` rises in the same cycle as the 0x080 issue.
- A write at edge W is visible to any character ISSUE at edge W+1 or later.

## Test plan
- Reset value check:
  - Drive `reset` high mid-simulation → all outputs are 0 within the same cycle (asynchronous).
  - `db`=0x000.
- Configuration sequence:
  - Stimulus: `init_done`=1, bench model of the instruction FSM returns `done` 1 cycle after `clk_cnt`=2080.
  - Required: `db` sequence 0x028, 0x006, 0x00C, 0x001.
  - Required: gap before 0x080 is exactly `CLEAR_WAIT`+1 cycles after `done`, and `config_done`=1.
- Default frame:
  - Required: 0x080, 16×0x220, 0x0C0, 16×0x220.
  - Required: `frame_done` is a single pulse.
  - Required: the next word is 0x080, not 0x028.
- Buffer write:
  - Stimulus: write 0x41 to address 17 before the frame.
  - Required: the second character of line 2 is `db`=0x241. All other characters remain 0x220.
- Write during the instruction in flight:
  - Stimulus: write to the entry currently being sent, while its instruction is in flight.
  - Required: `db` stays unchanged until the next ISSUE. The new value appears on the next frame.
- Reset mid-frame:
  - Stimulus: assert `reset` during step 12.
  - Required: outputs are 0 and the buffer returns to 0x20.
  - Required: after release with `init_done`=1, the next `db` is 0x028.
